serial_addsub5: RTL and testbench

//   Bit-serial WIDTH-bit two's-complement adder/subtractor with a start/done handshake.
//   It produces the same results as the combinational ripple add/sub stage: out_s, and out_c as carry/no-borrow.
//   It uses one full-adder slice over WIDTH cycles instead of WIDTH slices in one cycle.
//   It sits beside the ALU datapath as the area-reduced arithmetic path for multi-cycle ops.

---
 rtl/serial_addsub5.sv | 72 +++++++
 tb/tb_serial_addsub5.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_addsub5.sv
// serial_addsub5: bit-serial WIDTH-bit two's-complement add/subtract using one full-adder slice,
// with a start/busy/done handshake; one op every WIDTH+1 cycles.
module serial_addsub5 #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_v
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    count;
    logic             carry;
    logic             sum;
    logic             cout;
    logic             accept;

    assign busy   = state == RUN;
    assign done   = state == DONE;
    assign accept = start && state != RUN;
    assign sum    = a_sr[0] ^ b_sr[0] ^ carry;
    assign cout   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

    // Sum bits shift into the MSB of the A register as A drains, so after WIDTH
    // steps it holds the finished result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            count <= '0;
            carry <= 1'b0;
            out_s <= '0;
            out_c <= 1'b0;
            out_v <= 1'b0;
        end else if (accept) begin
            a_sr  <= in_a;
            b_sr  <= in_b ^ {WIDTH{in_c}};
            carry <= in_c;
            count <= '0;
            state <= RUN;
        end else if (state == RUN) begin
            a_sr  <= {sum, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            carry <= cout;
            count <= count + 1'b1;
            if (count == LAST) begin
                out_s <= {sum, a_sr[WIDTH-1:1]};
                out_c <= cout;
                out_v <= carry ^ cout;
                state <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_addsub5.sv
// tb_serial_addsub5: directed and random ops against an arithmetic reference model,
// plus handshake, back-to-back and mid-run reset checks.
module tb_serial_addsub5;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_c = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] out_s;
    logic         out_c;
    logic         out_v;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cyc = 0;

    serial_addsub5 #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .busy(busy), .done(done), .out_s(out_s), .out_c(out_c), .out_v(out_v)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Plain integer arithmetic: unsigned sum for carry, signed range test for overflow.
    task automatic model(input logic [W-1:0] a, b, input logic m,
                         output logic [W-1:0] s, output logic c, output logic v);
        int full, sa, sb, sr;
        full = int'(a) + (m ? (1 << W) - int'(b) : int'(b));
        s = W'(full);
        c = full >= (1 << W);
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        sr = m ? sa - sb : sa + sb;
        v = sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1));
    endtask

    // Called #1 after a rising edge with the DUT idle or in DONE.
    task automatic do_op(input logic [W-1:0] a, b, input logic m, input bit hold, input string tag);
        logic [W-1:0] es, prev;
        logic ec, ev;
        int cycles;
        model(a, b, m, es, ec, ev);
        prev = out_s;
        in_a = a; in_b = b; in_c = m; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom); in_c = 1'($urandom);
        chk({tag, ".busy"}, busy, 1);
        cycles = 0;
        while (!done && cycles < 3 * W) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == W - 1) start = 1'b0;
            if (cycles == 2) chk({tag, ".hold_s"}, out_s, prev);
        end
        done_cyc = cyc;
        chk({tag, ".lat"}, cycles, W);
        chk({tag, ".s"}, out_s, es);
        chk({tag, ".c"}, out_c, ec);
        chk({tag, ".v"}, out_v, ev);
    endtask

    initial begin
        int first_done;
        #2;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.s", out_s, 0);
        chk("rst.c", out_c, 0);
        chk("rst.v", out_v, 0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        do_op(5'd7, 5'd5, 1'b0, 1'b0, "add7_5");
        chk("add7_5.s_abs", out_s, 12);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        do_op(5'd3, 5'd5, 1'b1, 1'b0, "sub3_5");
        chk("sub3_5.s_abs", out_s, 30);
        do_op(5'd5, 5'd3, 1'b1, 1'b0, "sub5_3");
        first_done = done_cyc;
        do_op(5'd31, 5'd1, 1'b0, 1'b0, "add31_1");
        chk("b2b.gap", done_cyc - first_done, W + 1);
        do_op(5'd15, 5'd1, 1'b0, 1'b0, "add15_1");
        chk("add15_1.v_abs", out_v, 1);
        @(posedge clk); #1;
        do_op(5'd10, 5'd4, 1'b0, 1'b1, "held_start");
        @(posedge clk); #1;
        chk("held_start.idle", busy, 0);
        do_op(5'd16, 5'd1, 1'b1, 1'b0, "sub16_1");

        // Mid-run reset: outputs currently 15/1/1.
        @(posedge clk); #1;
        in_a = 5'd7; in_b = 5'd5; in_c = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("mid_rst.s", out_s, 0);
        chk("mid_rst.c", out_c, 0);
        chk("mid_rst.v", out_v, 0);
        chk("mid_rst.busy", busy, 0);
        repeat (W + 2) begin
            @(posedge clk); #1;
            chk("mid_rst.no_done", done, 0);
        end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        do_op(5'd9, 5'd9, 1'b1, 1'b0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin @(posedge clk); #1; end
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
